// File: rtl/frame_pipeline_ctrl.sv
// Per-frame sequencer for the crop-filter -> norm_reader -> output-FIFO path.
// Accepts a frame request when both stages are ready, latches the
// normalization denominator, fires both ap_start pulses together, then waits
// for crop-filter completion and a full frame of norm_reader output beats.
// A watchdog aborts a hung frame and pulses a downstream synchronous reset.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for frame_req with both stages ready
// START | one-cycle ap_start pulse to crop-filter and norm_reader
// RUN   | tracking cf_ap_done and counting output beats; watchdog armed
// DONE  | one-cycle frame_done pulse; completed-frame count advances
// ERR   | one-cycle frame_err and ds_srst pulse after a stall
module frame_pipeline_ctrl #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int OUT_ROWS        = 10,
  parameter int OUT_COLS        = 10,
  parameter int TIMEOUT_CYCLES  = 65536,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       s_axis_resetn,
  input  logic                       frame_req,
  input  logic [PIXEL_BIT_WIDTH-1:0] cfg_norm_denominator,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic [PIXEL_BIT_WIDTH-1:0] norm_denominator,
  output logic                       cf_ap_start,
  input  logic                       cf_ap_ready,
  input  logic                       cf_ap_done,
  output logic                       nr_ap_start,
  input  logic                       nr_ap_ready,
  input  logic                       nr_m_tvalid,
  input  logic                       nr_m_tready,
  output logic                       ds_srst
);

  localparam int N  = OUT_ROWS * OUT_COLS;
  localparam int BW = $clog2(N + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] N_B = BW'(N);
  localparam logic [WW-1:0] T_W = WW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, START, RUN, DONE, ERR} state_t;

  state_t                       state_q, state_d;
  logic [BW-1:0]                beat_q, beat_d;
  logic [WW-1:0]                wd_q, wd_d;
  logic                         seen_q, seen_d;
  logic [PIXEL_BIT_WIDTH-1:0]   denom_q, denom_d;
  logic [FRAME_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                         busy_q, busy_d;
  logic                         start_q, start_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;

  logic          beat;
  logic          activity;
  logic [BW-1:0] beat_nxt;
  logic [WW-1:0] wd_inc;
  logic          complete;

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wd_d     = wd_q;
    seen_d   = seen_q;
    denom_d  = denom_q;
    cnt_d    = cnt_q;

    beat     = nr_m_tvalid && nr_m_tready;
    activity = beat || cf_ap_done;
    // Saturate at N so trailing beats never push the count past a frame.
    beat_nxt = (beat && (beat_q != N_B)) ? beat_q + 1'b1 : beat_q;
    wd_inc   = wd_q + 1'b1;
    complete = (seen_q || cf_ap_done) && (beat_nxt == N_B);

    case (state_q)
      IDLE: begin
        if (frame_req && cf_ap_ready && nr_ap_ready) begin
          state_d = START;
          denom_d = cfg_norm_denominator;
          beat_d  = '0;
          seen_d  = 1'b0;
        end
      end
      START: begin
        state_d = RUN;
        wd_d    = '0;
      end
      RUN: begin
        seen_d = seen_q || cf_ap_done;
        beat_d = beat_nxt;
        wd_d   = activity ? '0 : wd_inc;
        if (complete) begin
          state_d = DONE;
          cnt_d   = cnt_q + 1'b1;
        end else if (!activity && (wd_inc == T_W)) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == START) || (state_d == RUN);
    start_d = (state_d == START);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERR);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      wd_q    <= '0;
      seen_q  <= 1'b0;
      denom_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wd_q    <= wd_d;
      seen_q  <= seen_d;
      denom_q <= denom_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign frame_err        = err_q;
  assign ds_srst          = err_q;
  assign frame_count      = cnt_q;
  assign norm_denominator = denom_q;
  assign cf_ap_start      = start_q;
  assign nr_ap_start      = start_q;

endmodule

// File: tb/tb_frame_pipeline_ctrl.sv
// Bench for frame_pipeline_ctrl: per-scenario tasks with a cycle-level
// behavioural model of frame completion and stall abort.
module tb_frame_pipeline_ctrl;

  localparam int PW      = 10;
  localparam int ROWS    = 10;
  localparam int COLS    = 10;
  localparam int TIMEOUT = 24;
  localparam int FW      = 16;
  localparam int N       = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_req;
  logic [PW-1:0] cfg;
  logic          busy, frame_done, frame_err, ds_srst;
  logic [FW-1:0] frame_count;
  logic [PW-1:0] norm_denominator;
  logic          cf_ap_start, cf_ap_ready, cf_ap_done;
  logic          nr_ap_start, nr_ap_ready, nr_m_tvalid, nr_m_tready;
  logic [5:0]    flags;

  int vecs = 0;
  int errs = 0;
  int model_count = 0;

  frame_pipeline_ctrl #(
    .PIXEL_BIT_WIDTH(PW),
    .OUT_ROWS(ROWS),
    .OUT_COLS(COLS),
    .TIMEOUT_CYCLES(TIMEOUT),
    .FRAME_CNT_WIDTH(FW)
  ) dut (
    .clk(clk),
    .s_axis_resetn(rst_n),
    .frame_req(frame_req),
    .cfg_norm_denominator(cfg),
    .busy(busy),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .frame_count(frame_count),
    .norm_denominator(norm_denominator),
    .cf_ap_start(cf_ap_start),
    .cf_ap_ready(cf_ap_ready),
    .cf_ap_done(cf_ap_done),
    .nr_ap_start(nr_ap_start),
    .nr_ap_ready(nr_ap_ready),
    .nr_m_tvalid(nr_m_tvalid),
    .nr_m_tready(nr_m_tready),
    .ds_srst(ds_srst)
  );

  assign flags = {frame_done, frame_err, ds_srst, busy, cf_ap_start, nr_ap_start};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic idle_inputs();
    frame_req   = 1'b0;
    cf_ap_ready = 1'b1;
    nr_ap_ready = 1'b1;
    cf_ap_done  = 1'b0;
    nr_m_tvalid = 1'b0;
    nr_m_tready = 1'b0;
  endtask

  // done_at: RUN-cycle index of cf_ap_done; -1 = together with Nth beat; -2 = never.
  // cfg_mode: 0 = hold, 1 = random every cycle, 2 = change to 5 at RUN cycle 10.
  task automatic run_frame(input string tag, input int done_at, input int beat_from,
                           input int vpct, input int rpct, input logic [PW-1:0] cfg_val,
                           input int cfg_mode, input bit extra_beat);
    int            cnt, idle, k, waited;
    bit            seen, beat, complete, timeout, ended;
    logic [PW-1:0] latched;
    logic [5:0]    exp_flags;
    cnt = 0; idle = 0; seen = 0; ended = 0; complete = 0; timeout = 0;
    latched = cfg_val;
    idle_inputs();
    cfg = cfg_val;
    frame_req = 1'b1;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!cf_ap_start && waited < 20);
    vecs++;
    if (flags !== 6'b000111 || norm_denominator !== latched) begin
      errs++;
      $display("FAIL %s_start: flags=%b den=%0d, expected flags=000111 den=%0d",
               tag, flags, norm_denominator, latched);
    end
    if (!cf_ap_start) return;
    frame_req = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (flags !== 6'b000100) begin
      errs++;
      $display("FAIL %s_start_width: flags=%b, expected 000100", tag, flags);
    end
    for (k = 0; k < 1000 && !ended; k++) begin
      nr_m_tvalid = (k >= beat_from) && ($urandom_range(99) < vpct);
      nr_m_tready = ($urandom_range(99) < rpct);
      beat = nr_m_tvalid && nr_m_tready;
      cf_ap_done = (done_at == k) || (done_at == -1 && beat && cnt == N - 1);
      if (cfg_mode == 1) cfg = PW'($urandom);
      if (cfg_mode == 2 && k == 10) cfg = 10'd5;
      if (cf_ap_done) seen = 1;
      if (beat && cnt < N) cnt++;
      complete = seen && (cnt == N);
      idle = (beat || cf_ap_done) ? 0 : idle + 1;
      timeout = !complete && (idle == TIMEOUT);
      @(posedge clk); #1;
      exp_flags = {complete, timeout, timeout, !(complete || timeout), 2'b00};
      vecs++;
      if (flags !== exp_flags || norm_denominator !== latched) begin
        errs++;
        $display("FAIL %s_run k=%0d: flags=%b den=%0d, expected flags=%b den=%0d",
                 tag, k, flags, norm_denominator, exp_flags, latched);
      end
      ended = complete || timeout;
    end
    if (!ended) begin
      vecs++;
      errs++;
      $display("FAIL %s_end: frame still running after %0d cycles, expected done or err", tag, k);
    end
    if (complete) model_count++;
    if (!extra_beat) begin
      cf_ap_done = 1'b0;
      nr_m_tvalid = 1'b0;
      nr_m_tready = 1'b0;
    end else begin
      nr_m_tvalid = 1'b1;
      nr_m_tready = 1'b1;
    end
    @(posedge clk); #1;
    vecs++;
    if (flags !== 6'b0 || frame_count !== FW'(model_count)) begin
      errs++;
      $display("FAIL %s_exit: flags=%b count=%0d, expected flags=000000 count=%0d",
               tag, flags, frame_count, model_count);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    cfg = 10'd123;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({flags, frame_count, norm_denominator} !== '0) begin
      errs++;
      $display("FAIL reset: flags=%b count=%0d den=%0d, expected all 0",
               flags, frame_count, norm_denominator);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (flags !== 6'b0) begin
      errs++;
      $display("FAIL reset_release: flags=%b, expected 000000", flags);
    end
  endtask

  task automatic test_basic();
    run_frame("basic", 19, 20, 100, 100, 10'd77, 0, 0);
  endtask

  task automatic test_ready_gate();
    int w;
    idle_inputs();
    frame_req = 1'b1;
    cf_ap_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i >= 8) begin cf_ap_ready = 1'b1; nr_ap_ready = 1'b0; end
      @(posedge clk); #1;
      vecs++;
      if (flags !== 6'b0) begin
        errs++;
        $display("FAIL ready_gate i=%0d: flags=%b, expected 000000", i, flags);
      end
    end
    nr_ap_ready = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (flags !== 6'b000111) begin
      errs++;
      $display("FAIL ready_rise_start: flags=%b, expected 000111", flags);
    end
    frame_req = 1'b0;
    @(posedge clk); #1;
    nr_m_tvalid = 1'b1;
    nr_m_tready = 1'b1;
    cf_ap_done  = 1'b1;
    w = 0;
    do begin
      @(posedge clk); #1;
      cf_ap_done = 1'b0;
      w++;
    end while (!frame_done && w < 300);
    vecs++;
    if (!frame_done || w !== N) begin
      errs++;
      $display("FAIL ready_frame_done: done=%0b after %0d cycles, expected 1 after %0d",
               frame_done, w, N);
    end
    if (frame_done) model_count++;
    idle_inputs();
    @(posedge clk); #1;
    vecs++;
    if (frame_count !== FW'(model_count)) begin
      errs++;
      $display("FAIL ready_count: count=%0d, expected %0d", frame_count, model_count);
    end
  endtask

  task automatic test_coincide();
    run_frame("coincide", -1, 0, 100, 100, 10'd300, 0, 1);
  endtask

  task automatic test_cfg_hold();
    run_frame("cfg_hold", 30, 0, 100, 100, 10'd37, 2, 0);
    run_frame("cfg_next", 0, 0, 100, 100, 10'd5, 1, 0);
  endtask

  task automatic test_watchdog();
    run_frame("watchdog", -2, 100000, 0, 0, 10'd9, 0, 0);
  endtask

  task automatic test_idle_noise();
    idle_inputs();
    for (int i = 0; i < 20; i++) begin
      nr_m_tvalid = $urandom_range(1);
      nr_m_tready = $urandom_range(1);
      cf_ap_done  = $urandom_range(1);
      @(posedge clk); #1;
      vecs++;
      if (flags !== 6'b0) begin
        errs++;
        $display("FAIL idle_noise i=%0d: flags=%b, expected 000000", i, flags);
      end
    end
    run_frame("after_noise", 50, 0, 100, 100, 10'd600, 0, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      run_frame("random", $urandom_range(150), $urandom_range(10),
                40 + $urandom_range(60), 40 + $urandom_range(60),
                PW'($urandom), 1, bit'($urandom_range(1)));
    end
  endtask

  task automatic test_reset_mid_frame();
    int w;
    idle_inputs();
    frame_req = 1'b1;
    w = 0;
    do begin @(posedge clk); #1; w++; end while (!cf_ap_start && w < 20);
    frame_req = 1'b0;
    @(posedge clk); #1;
    nr_m_tvalid = 1'b1;
    nr_m_tready = 1'b1;
    repeat (50) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vecs++;
    if ({flags, frame_count, norm_denominator} !== '0) begin
      errs++;
      $display("FAIL reset_mid: flags=%b count=%0d den=%0d, expected all 0",
               flags, frame_count, norm_denominator);
    end
    idle_inputs();
    model_count = 0;
    @(negedge clk) rst_n = 1'b1;
    run_frame("post_reset", 10, 0, 100, 100, 10'd444, 0, 0);
    vecs++;
    if (frame_count !== FW'(1)) begin
      errs++;
      $display("FAIL post_reset_count: count=%0d, expected 1", frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_gate();
    test_coincide();
    test_cfg_hold();
    test_watchdog();
    test_idle_noise();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
